// File: rtl/demux4_tdm_pkg.sv
// Shared types and constants for the 4-lane TDM demultiplexer.
package demux4_tdm_pkg;

  typedef logic [1:0] slot_t;

  localparam int unsigned LANE_NUM  = 4;
  localparam slot_t       SLOT_LAST = 2'd3;

endpackage

// File: rtl/demux4_tdm_slotcnt.sv
// 2-bit slot counter with synchronous start-of-frame realign; flags frame completion
// and start-of-frame arriving mid-frame.
module demux4_tdm_slotcnt
  import demux4_tdm_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  dv_i,
  input  logic  sof_i,
  output slot_t slot_o,
  output logic  done_o,
  output logic  misalign_o
);

  slot_t slot_q, slot_d;

  // A valid start-of-frame sample occupies lane 0, so the counter lands on lane 1.
  always_comb begin
    slot_d = slot_q;
    if (sof_i) begin
      slot_d = dv_i ? slot_t'(1) : slot_t'(0);
    end else if (dv_i) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o     = slot_q;
  assign done_o     = dv_i & ~sof_i & (slot_q == SLOT_LAST);
  assign misalign_o = sof_i & (slot_q != slot_t'(0));

endmodule

// File: rtl/demux4_tdm.sv
// 1:4 time-division demultiplexer: stages lanes 0..2, publishes a full frame with the
// lane-3 sample. Define DEMUX4_TDM_ERR_EN to add the ERR misaligned-SOF strobe.
module demux4_tdm
  import demux4_tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             SOF,
  output logic [WIDTH-1:0] Z0,
  output logic [WIDTH-1:0] Z1,
  output logic [WIDTH-1:0] Z2,
  output logic [WIDTH-1:0] Z3,
  output logic             ZV,
`ifdef DEMUX4_TDM_ERR_EN
  output logic             ERR,
`endif
  output logic [1:0]       SLOT
);

  slot_t slot;
  slot_t lane;
  logic  done;
  logic  misalign;

  logic [WIDTH-1:0] stg_q [LANE_NUM-1];
  logic [WIDTH-1:0] stg_d [LANE_NUM-1];
  logic [WIDTH-1:0] z_q   [LANE_NUM];
  logic [WIDTH-1:0] z_d   [LANE_NUM];
  logic             zv_q, zv_d;

  demux4_tdm_slotcnt u_slotcnt (
    .clk_i      (CK),
    .rst_ni     (RSTN),
    .dv_i       (DV),
    .sof_i      (SOF),
    .slot_o     (slot),
    .done_o     (done),
    .misalign_o (misalign)
  );

  assign lane = SOF ? slot_t'(0) : slot;

  // Lane 3 is never staged: its sample goes straight to Z3 on the completing edge.
  always_comb begin
    stg_d = stg_q;
    z_d   = z_q;
    zv_d  = done;
    if (DV && (lane != SLOT_LAST)) begin
      stg_d[lane] = D;
    end
    if (done) begin
      for (int i = 0; i < int'(LANE_NUM) - 1; i++) begin
        z_d[i] = stg_q[i];
      end
      z_d[LANE_NUM-1] = D;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < int'(LANE_NUM) - 1; i++) begin
        stg_q[i] <= '0;
      end
      for (int i = 0; i < int'(LANE_NUM); i++) begin
        z_q[i] <= '0;
      end
      zv_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      z_q   <= z_d;
      zv_q  <= zv_d;
    end
  end

`ifdef DEMUX4_TDM_ERR_EN
  logic err_q;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      err_q <= 1'b0;
    end else begin
      err_q <= misalign;
    end
  end

  assign ERR = err_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
`endif

  assign Z0   = z_q[0];
  assign Z1   = z_q[1];
  assign Z2   = z_q[2];
  assign Z3   = z_q[3];
  assign ZV   = zv_q;
  assign SLOT = slot;

endmodule

// File: tb/tb_demux4_tdm.sv
// Self-checking bench for demux4_tdm: directed scenarios plus random traffic against
// a frame-queue reference model.
module tb_demux4_tdm;

  localparam int unsigned W = 8;

  logic         CK = 1'b0;
  logic         RSTN;
  logic [W-1:0] D;
  logic         DV;
  logic         SOF;
  logic [W-1:0] Z0, Z1, Z2, Z3;
  logic         ZV;
  logic [1:0]   SLOT;
`ifdef DEMUX4_TDM_ERR_EN
  logic         ERR;
`endif

  demux4_tdm #(.WIDTH(W)) dut (
    .CK   (CK),
    .RSTN (RSTN),
    .D    (D),
    .DV   (DV),
    .SOF  (SOF),
    .Z0   (Z0),
    .Z1   (Z1),
    .Z2   (Z2),
    .Z3   (Z3),
    .ZV   (ZV),
`ifdef DEMUX4_TDM_ERR_EN
    .ERR  (ERR),
`endif
    .SLOT (SLOT)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;
  int zv_seen = 0;
  int err_seen = 0;

  // Reference model: samples of the frame in progress, last published frame, strobes.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_z [4];
  logic         exp_zv;
  logic         exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".slot"}, 32'(SLOT), 32'(mq.size()));
    chk({tag, ".zv"}, 32'(ZV), 32'(exp_zv));
    chk({tag, ".z0"}, 32'(Z0), 32'(exp_z[0]));
    chk({tag, ".z1"}, 32'(Z1), 32'(exp_z[1]));
    chk({tag, ".z2"}, 32'(Z2), 32'(exp_z[2]));
    chk({tag, ".z3"}, 32'(Z3), 32'(exp_z[3]));
`ifdef DEMUX4_TDM_ERR_EN
    chk({tag, ".err"}, 32'(ERR), 32'(exp_err));
    if (ERR === 1'b1) err_seen++;
`endif
    if (ZV === 1'b1) zv_seen++;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) exp_z[i] = '0;
    exp_zv  = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic step(input string tag, input logic dv, input logic sof, input logic [W-1:0] d);
    DV = dv; SOF = sof; D = d;
    @(posedge CK);
    exp_zv  = 1'b0;
    exp_err = sof && (mq.size() != 0);
    if (sof) mq.delete();
    if (dv) mq.push_back(d);
    if (mq.size() == 4) begin
      for (int i = 0; i < 4; i++) exp_z[i] = mq[i];
      exp_zv = 1'b1;
      mq.delete();
    end
    #1;
    DV = 1'b0; SOF = 1'b0;
    chk_all(tag);
  endtask

  // Asserted between edges so the immediate (asynchronous) clear is observable.
  task automatic pulse_reset(input string tag);
    #2;
    RSTN = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge CK);
    RSTN = 1'b1;
  endtask

  initial begin
    RSTN = 1'b0; DV = 1'b0; SOF = 1'b0; D = '0;
    model_reset();
    #3;
    chk_all("reset");
    @(negedge CK);
    RSTN = 1'b1;

    // 1,0,1,1 with SOF on the first sample
    step("r27a", 1'b1, 1'b1, 8'h01);
    step("r27b", 1'b1, 1'b0, 8'h00);
    step("r27c", 1'b1, 1'b0, 8'h01);
    step("r27d", 1'b1, 1'b0, 8'h01);
    chk("r27.z", {Z0, Z1, Z2, Z3}, 32'h01000101);
    chk("r27.zv", 32'(ZV), 32'd1);
    step("r27e", 1'b0, 1'b0, 8'h00);
    chk("r27.zv_drop", 32'(ZV), 32'd0);

    // Back-to-back frames 0x10..0x17
    zv_seen = 0;
    for (int i = 0; i < 8; i++) step("r28", 1'b1, 1'b0, 8'(8'h10 + i));
    chk("r28.frame2", {Z0, Z1, Z2, Z3}, 32'h14151617);
    chk("r28.zv_count", 32'(zv_seen), 32'd2);

    // Partial frame dropped by a mid-frame SOF
    err_seen = 0;
    step("r29a", 1'b1, 1'b0, 8'h0a);
    step("r29b", 1'b1, 1'b0, 8'h0b);
    step("r29c", 1'b1, 1'b1, 8'h0c);
    for (int i = 0; i < 3; i++) step("r29d", 1'b1, 1'b0, 8'(8'h0d + i));
    chk("r29.z0", 32'(Z0), 32'h0c);
`ifdef DEMUX4_TDM_ERR_EN
    chk("r29.err_count", 32'(err_seen), 32'd1);
`endif

    // Idle gaps between samples
    zv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step("r30s", 1'b1, 1'b0, 8'(8'h20 + i));
      for (int g = 0; g <= i % 3; g++) step("r30g", 1'b0, 1'b0, 8'hff);
    end
    chk("r30.z", {Z0, Z1, Z2, Z3}, 32'h20212223);
    chk("r30.zv_count", 32'(zv_seen), 32'd1);

    // SOF without DV realigns but keeps staging intact
    step("sofidle_a", 1'b1, 1'b0, 8'h31);
    step("sofidle_b", 1'b0, 1'b1, 8'h00);

    // Reset mid-frame
    step("r31a", 1'b1, 1'b0, 8'h40);
    step("r31b", 1'b1, 1'b0, 8'h41);
    pulse_reset("r31.rst");
    for (int i = 0; i < 4; i++) step("r31c", 1'b1, 1'b0, 8'(8'h50 + i));
    chk("r31.z", {Z0, Z1, Z2, Z3}, 32'h50515253);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd.rst");
      end else begin
        step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux4_tdm.md
DEMUX4_TDM -- requirements
Module: demux4_tdm

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data sample and of each lane output.
REQ-002 CK  input  1  clock; all state updates on the rising edge.
REQ-003 RSTN  input  1  asynchronous active-low reset.
REQ-004 D  input  WIDTH  serial time-division sample stream.
REQ-005 DV  input  1  sample-valid qualifier; D is consumed only on edges where DV=1.
REQ-006 SOF  input  1  start-of-frame; marks D as the lane-0 sample when DV=1, and realigns the slot counter.
REQ-007 Z0, Z1, Z2, Z3  output  WIDTH each  demultiplexed lane outputs, registered.
REQ-008 ZV  output  1  one-cycle strobe: Z0..Z3 hold a newly completed frame.
REQ-009 SLOT  output  2  current slot counter; the lane index that the next valid sample will fill.

Function
REQ-010 The block SHALL route each valid sample to lane SLOT, so that Z0..Z3 reproduce D0..D3 of the 4:1 select order (lane 0 = select 00, lane 3 = select 11).
REQ-011 On DV=1 and SOF=0, the block SHALL store D in the lane-SLOT staging register and SHALL set SLOT to SLOT+1 mod 4.
REQ-012 On DV=1 and SOF=1, the block SHALL store D in the lane-0 staging register and SHALL set SLOT to 1, discarding any partial frame.
REQ-013 On DV=0 and SOF=1, the block SHALL set SLOT to 0, discard the partial frame and leave the staging registers unchanged.
REQ-014 On DV=0 and SOF=0, SLOT and all registers SHALL hold.
REQ-015 When a valid sample is consumed with SLOT=3 and SOF=0, on the same edge the block SHALL load Z0..Z2 from staging and Z3 from D, and SHALL set SLOT to 0.
REQ-016 ZV SHALL be 1 for exactly the cycle following the REQ-015 edge and 0 otherwise; latency from the slot-3 sample edge to valid Z0..Z3 and ZV is one edge.
REQ-017 Z0..Z3 SHALL hold their values between frame completions; partial frames SHALL never alter Z0..Z3.
REQ-018 Back-to-back frames (DV=1 every cycle) SHALL produce ZV on every fourth cycle with no lost sample.
REQ-019 Wrap-around of SLOT from 3 to 0 SHALL occur only via REQ-015 or REQ-012/013.

Reset
REQ-020 RSTN=0 SHALL immediately force SLOT=0, ZV=0, Z0..Z3=0, all staging registers=0, and ERR=0 when it is present.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; the first valid sample after release SHALL go to lane 0.
REQ-022 Release of RSTN SHALL take effect at the first rising CK edge after deassertion.

Configuration
REQ-023 With macro DEMUX4_TDM_ERR_EN defined, the block SHALL add output ERR (1 bit), which pulses high for one cycle after any edge on which SOF=1 arrives while SLOT!=0.
REQ-024 With DEMUX4_TDM_ERR_EN undefined, the block SHALL omit the ERR port and its logic; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package SHALL hold the slot-index typedef (2-bit), the constants LANE_NUM=4 and SLOT_LAST=3, and no module-specific logic.
REQ-026 The 2-bit slot counter with sync realign SHALL be a sub-module named demux4_tdm_slotcnt; the lane registers stay in the top level.

Verification
REQ-027 Reset, then DV=1 on 4 cycles with D=1,0,1,1 and SOF on the first cycle -> Z0..Z3=1,0,1,1; ZV high for one cycle after the 4th edge; SLOT=0.
REQ-028 WIDTH=8, continuous DV for 8 cycles with D=0x10..0x17 -> ZV twice, 4 cycles apart; frames 10,11,12,13 and 14,15,16,17.
REQ-029 Two samples (0xA, 0xB), then SOF with DV and D=0xC, then 3 more samples -> the partial frame is dropped; Z0=0xC; ERR pulses once when DEMUX4_TDM_ERR_EN is defined.
REQ-030 DV gaps: samples separated by 1-3 idle cycles -> same Z values as without gaps; no ZV during the gaps.
REQ-031 RSTN pulsed low after 2 samples -> all outputs 0 immediately; the next 4 samples form a correct frame starting at lane 0.
